// File: rtl/mc_datapath_p_if.sv
// Bus between the multicycle controller / unified memory and mc_datapath_p.
//   master : controller + memory side (drives control strobes, memdata, mem_valid)
//   slave  : datapath side (drives adr, writedata, instr, pc, zero, fetch status)
interface mc_datapath_p_if #(parameter int XLEN = 8);
  logic            fetch_start;
  logic            mem_valid;
  logic [XLEN-1:0] memdata;
  logic            alusrca;
  logic [1:0]      alusrcb;
  logic [2:0]      alucontrol;
  logic [1:0]      pcsrc;
  logic            pcwrite;
  logic            branch;
  logic            iord;
  logic            regwrite;
  logic            regdst;
  logic            memtoreg;
  logic [XLEN-1:0] adr;
  logic [XLEN-1:0] writedata;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            zero;
  logic            fetch_busy;
  logic            ir_done;

  modport master (
    output fetch_start, mem_valid, memdata, alusrca, alusrcb, alucontrol, pcsrc,
           pcwrite, branch, iord, regwrite, regdst, memtoreg,
    input  adr, writedata, instr, pc, zero, fetch_busy, ir_done
  );

  modport slave (
    input  fetch_start, mem_valid, memdata, alusrca, alusrcb, alucontrol, pcsrc,
           pcwrite, branch, iord, regwrite, regdst, memtoreg,
    output adr, writedata, instr, pc, zero, fetch_busy, ir_done
  );
endinterface

// File: rtl/mc_datapath_p.sv
// Parametrised multicycle processor datapath with built-in instruction fetch.
// A 32-bit instruction is fetched in BEATS = 32/XLEN memory beats (least
// significant first) while the fetch FSM is in FETCH; pc and register file
// writes are blocked during the fetch.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mc_datapath_p_if.slave -- control strobes and memory read
//                data in; adr, writedata, instr, pc, zero, fetch_busy,
//                ir_done out
module mc_datapath_p #(
  parameter int XLEN = 8,
  parameter int NREG = 8
) (
  input  logic           clk,
  input  logic           reset,
  mc_datapath_p_if.slave bus
);
  localparam int BEATS = 32 / XLEN;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(NREG);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                       state_q, state_d;
  logic [BW-1:0]                beat_q, beat_d;
  logic [31:0]                  instr_q, instr_d;
  logic [XLEN-1:0]              pc_q, pc_d;
  logic [XLEN-1:0]              a_q, a_d;
  logic [XLEN-1:0]              b_q, b_d;
  logic [XLEN-1:0]              aluout_q, aluout_d;
  logic [XLEN-1:0]              data_q, data_d;
  logic                         ir_done_q, ir_done_d;
  logic [NREG-1:0][XLEN-1:0]    rf_q, rf_d;

  logic                         fetching, last_beat, pc_en;
  logic [AW-1:0]                ra1, ra2, wa;
  logic [XLEN-1:0]              wd, simm, simm_x, jt, srca, srcb, aluresult, nextpc;

  assign fetching  = (state_q == FETCH);
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // Fetch sequencer: each accepted beat lands in its own XLEN slice of instr.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    instr_d   = instr_q;
    ir_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.fetch_start) begin
          state_d = FETCH;
          beat_d  = '0;
        end
      end
      FETCH: begin
        if (bus.mem_valid) begin
          for (int i = 0; i < BEATS; i++)
            if (beat_q == BW'(i)) instr_d[i*XLEN +: XLEN] = bus.memdata;
          if (last_beat) begin
            state_d   = IDLE;
            beat_d    = '0;
            ir_done_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Operand decode; register addresses are truncated to the file size.
  assign ra1    = instr_q[21 +: AW];
  assign ra2    = instr_q[16 +: AW];
  assign wa     = bus.regdst ? instr_q[11 +: AW] : instr_q[16 +: AW];
  assign wd     = bus.memtoreg ? data_q : aluout_q;
  assign simm   = XLEN'({{16{instr_q[15]}}, instr_q[15:0]});
  assign simm_x = simm * XLEN'(BEATS);
  assign jt     = XLEN'({6'b0, instr_q[25:0]} * 32'(BEATS));

  always_comb begin
    srca = bus.alusrca ? a_q : pc_q;
    unique case (bus.alusrcb)
      2'b00:   srcb = b_q;
      2'b01:   srcb = XLEN'(BEATS);
      2'b10:   srcb = simm;
      default: srcb = simm_x;
    endcase
  end

  always_comb begin
    unique case (bus.alucontrol)
      3'b000:  aluresult = srca & srcb;
      3'b001:  aluresult = srca | srcb;
      3'b010:  aluresult = srca + srcb;
      3'b110:  aluresult = srca - srcb;
      3'b111:  aluresult = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: aluresult = '0;
    endcase
  end

  always_comb begin
    unique case (bus.pcsrc)
      2'b00:   nextpc = aluresult;
      2'b01:   nextpc = aluout_q;
      default: nextpc = jt;
    endcase
  end

  // pcsrc 11 means "hold", so it vetoes both pcwrite and a taken branch.
  assign pc_en = (bus.pcwrite | (bus.branch & bus.zero)) & ~fetching & (bus.pcsrc != 2'b11);

  always_comb begin
    pc_d     = pc_en ? nextpc : pc_q;
    a_d      = rf_q[ra1];
    b_d      = rf_q[ra2];
    aluout_d = aluresult;
    data_d   = (bus.mem_valid && !fetching) ? bus.memdata : data_q;
    rf_d     = rf_q;
    // r0 is never written, so its reset value keeps it reading zero.
    if (bus.regwrite && !fetching && wa != '0) rf_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      instr_q   <= '0;
      pc_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      data_q    <= '0;
      ir_done_q <= 1'b0;
      rf_q      <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluout_q  <= aluout_d;
      data_q    <= data_d;
      ir_done_q <= ir_done_d;
      rf_q      <= rf_d;
    end
  end

  assign bus.adr        = fetching ? (pc_q + XLEN'(beat_q)) : (bus.iord ? aluout_q : pc_q);
  assign bus.writedata  = b_q;
  assign bus.instr      = instr_q;
  assign bus.pc         = pc_q;
  assign bus.zero       = (aluresult == '0);
  assign bus.fetch_busy = fetching;
  assign bus.ir_done    = ir_done_q;
endmodule

// File: tb/tb_mc_datapath_p.sv
// Bench for mc_datapath_p: an XLEN=8 instance checked every cycle against an
// ISA-level reference model (directed scenarios, then random traffic), and an
// XLEN=16 instance for a stalled two-beat fetch.
module tb_mc_datapath_p;
  logic clk = 1'b0;
  logic rst8, rst16;
  always #5 clk = ~clk;

  mc_datapath_p_if #(.XLEN(8))  if8  ();
  mc_datapath_p_if #(.XLEN(16)) if16 ();

  mc_datapath_p #(.XLEN(8),  .NREG(8)) u_dut8  (.clk(clk), .reset(rst8),  .bus(if8));
  mc_datapath_p #(.XLEN(16), .NREG(8)) u_dut16 (.clk(clk), .reset(rst16), .bus(if16));

  int n_chk = 0, n_pass = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model (XLEN=8, NREG=8, 4 beats) ----------------
  localparam int M = 255;
  int          m_pc, m_a, m_b, m_alo, m_data, m_beat;
  logic [31:0] m_instr;
  int          m_rf [8];
  bit          m_fetch, m_done;

  task automatic mdl_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_alo = 0; m_data = 0; m_beat = 0;
    m_instr = 0; m_fetch = 0; m_done = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
  endtask

  task automatic mdl_comb(output int alu, output int adr, output bit z);
    int sa, sb, simm;
    byte ba, bb;
    shortint s16;
    s16  = m_instr[15:0];
    simm = int'(s16) & M;
    sa   = if8.alusrca ? m_a : m_pc;
    case (if8.alusrcb)
      2'd0:    sb = m_b;
      2'd1:    sb = 4;
      2'd2:    sb = simm;
      default: sb = (simm * 4) & M;
    endcase
    ba = byte'(sa);
    bb = byte'(sb);
    case (if8.alucontrol)
      3'b000:  alu = sa & sb;
      3'b001:  alu = sa | sb;
      3'b010:  alu = (sa + sb) & M;
      3'b110:  alu = (sa - sb) & M;
      3'b111:  alu = (ba < bb) ? 1 : 0;
      default: alu = 0;
    endcase
    z   = (alu == 0);
    adr = m_fetch ? ((m_pc + m_beat) & M) : (if8.iord ? m_alo : m_pc);
  endtask

  task automatic mdl_step();
    int alu, adr, npc, wa, wd, na, nb;
    bit z;
    if (rst8) begin
      mdl_reset();
      return;
    end
    mdl_comb(alu, adr, z);
    na = m_rf[m_instr[23:21]];
    nb = m_rf[m_instr[18:16]];
    wa = if8.regdst ? m_instr[13:11] : m_instr[18:16];
    wd = if8.memtoreg ? m_data : m_alo;
    case (if8.pcsrc)
      2'd0:    npc = alu;
      2'd1:    npc = m_alo;
      default: npc = (m_instr[25:0] * 4) & M;
    endcase
    if (!m_fetch && if8.pcsrc != 2'd3 && (if8.pcwrite || (if8.branch && z))) m_pc = npc;
    if (!m_fetch && if8.regwrite && wa != 0) m_rf[wa] = wd;
    if (!m_fetch && if8.mem_valid) m_data = if8.memdata;
    m_a = na; m_b = nb; m_alo = alu;
    m_done = 0;
    if (!m_fetch) begin
      if (if8.fetch_start) begin m_fetch = 1; m_beat = 0; end
    end else if (if8.mem_valid) begin
      m_instr[m_beat*8 +: 8] = if8.memdata;
      if (m_beat == 3) begin m_fetch = 0; m_done = 1; m_beat = 0; end
      else m_beat++;
    end
  endtask

  // One clock of the 8-bit DUT: check outputs mid-cycle, advance model, clock.
  task automatic cyc();
    int alu, adr;
    bit z;
    @(negedge clk);
    mdl_comb(alu, adr, z);
    chk("adr",     if8.adr,        adr);
    chk("zero",    if8.zero,       z);
    chk("pc",      if8.pc,         m_pc);
    chk("instr",   if8.instr,      m_instr);
    chk("wdata",   if8.writedata,  m_b);
    chk("busy",    if8.fetch_busy, m_fetch);
    chk("ir_done", if8.ir_done,    m_done);
    if (if8.ir_done) done_cnt++;
    mdl_step();
    @(posedge clk); #1;
  endtask

  task automatic idle8();
    if8.fetch_start = 0; if8.mem_valid = 0; if8.memdata = 0;
    if8.alusrca = 0; if8.alusrcb = 0; if8.alucontrol = 0; if8.pcsrc = 0;
    if8.pcwrite = 0; if8.branch = 0; if8.iord = 0;
    if8.regwrite = 0; if8.regdst = 0; if8.memtoreg = 0;
  endtask

  task automatic idle16();
    if16.fetch_start = 0; if16.mem_valid = 0; if16.memdata = 0;
    if16.alusrca = 0; if16.alusrcb = 0; if16.alucontrol = 0; if16.pcsrc = 0;
    if16.pcwrite = 0; if16.branch = 0; if16.iord = 0;
    if16.regwrite = 0; if16.regdst = 0; if16.memtoreg = 0;
  endtask

  task automatic fetch8(input logic [31:0] w);
    if8.fetch_start = 1; cyc(); if8.fetch_start = 0;
    for (int i = 0; i < 4; i++) begin
      if8.mem_valid = 1; if8.memdata = w[i*8 +: 8]; cyc();
    end
    if8.mem_valid = 0;
  endtask

  initial begin
    int mv_t [5]  = '{0, 1, 0, 0, 1};
    int adr_t [5] = '{0, 0, 1, 1, 1};
    idle8(); idle16();
    rst8 = 1; rst16 = 1;
    repeat (2) @(posedge clk); #1;
    mdl_reset(); rst8 = 0;
    chk("rst_pc", if8.pc, 0);
    chk("rst_instr", if8.instr, 0);
    chk("rst_busy", if8.fetch_busy, 0);
    chk("rst_done", if8.ir_done, 0);

    // 4-beat fetch, back-to-back mem_valid
    done_cnt = 0;
    if8.fetch_start = 1; cyc(); if8.fetch_start = 0;
    for (int i = 0; i < 4; i++) begin
      if8.mem_valid = 1; if8.memdata = 8'(8'h11 * (i + 1));
      #1 chk("f8_adr", if8.adr, i);
      cyc();
    end
    if8.mem_valid = 0;
    chk("f8_instr", if8.instr, 32'h44332211);
    repeat (3) cyc();
    chk("f8_done_once", done_cnt, 1);

    // pc = 0 + simm(0xFF), then pc + BEATS wraps to 3
    fetch8(32'h000000FF);
    cyc();
    if8.alusrca = 1; if8.alusrcb = 2; if8.alucontrol = 3'b010; if8.pcwrite = 1; if8.pcsrc = 0;
    cyc();
    chk("pc_ff", if8.pc, 8'hFF);
    if8.alusrca = 0; if8.alusrcb = 1;
    cyc();
    chk("pc_wrap", if8.pc, 8'h03);
    idle8();

    // r1 = r2 = 5 via OR with simm 5, then branch-on-equal
    fetch8(32'h00220805);
    cyc();
    if8.alusrca = 1; if8.alusrcb = 2; if8.alucontrol = 3'b001;
    cyc();
    if8.regwrite = 1; if8.regdst = 1; cyc();
    if8.regdst = 0; cyc();
    if8.regwrite = 0; cyc();
    if8.alusrcb = 0; if8.alucontrol = 3'b110; if8.branch = 1; if8.pcsrc = 1;
    #1 chk("br_zero", if8.zero, 1);
    cyc();
    chk("br_taken_pc", if8.pc, 5);
    if8.branch = 0;
    if8.mem_valid = 1; if8.memdata = 6; cyc();
    if8.mem_valid = 0; if8.regwrite = 1; if8.regdst = 0; if8.memtoreg = 1; cyc();
    if8.regwrite = 0; if8.memtoreg = 0; cyc();
    chk("r2_six", if8.writedata, 6);
    if8.branch = 1;
    #1 chk("br_nz", if8.zero, 0);
    cyc();
    chk("br_not_taken_pc", if8.pc, 5);
    idle8();

    // r0 write discarded; r3 write-while-read bypass timing
    fetch8(32'h0060187F);
    cyc();
    if8.alusrca = 1; if8.alusrcb = 2; if8.alucontrol = 3'b010;
    cyc();
    if8.regwrite = 1; if8.regdst = 0; cyc();
    if8.regwrite = 0; cyc(); cyc();
    chk("r0_zero", if8.writedata, 0);
    if8.regwrite = 1; if8.regdst = 1; if8.alusrcb = 0; if8.alucontrol = 3'b001;
    cyc();
    if8.regwrite = 0; if8.iord = 1;
    #1 chk("r3_old", if8.zero, 1);
    cyc();
    chk("r3_new", if8.zero, 0);
    cyc();
    chk("r3_adr", if8.adr, 8'h7F);
    idle8();

    // reset on beat 2 abandons the fetch
    if8.fetch_start = 1; cyc(); if8.fetch_start = 0;
    if8.mem_valid = 1; if8.memdata = 8'hAA; cyc();
    if8.memdata = 8'hBB; cyc();
    if8.memdata = 8'hCC; rst8 = 1; cyc();
    rst8 = 0; if8.mem_valid = 0;
    chk("rst_mid_instr", if8.instr, 0);
    chk("rst_mid_busy", if8.fetch_busy, 0);
    if8.fetch_start = 1; cyc(); if8.fetch_start = 0;
    #1 chk("refetch_adr0", if8.adr, 0);
    chk("refetch_busy", if8.fetch_busy, 1);
    if8.mem_valid = 1; if8.memdata = 8'h5A; cyc();
    chk("refetch_adr1", if8.adr, 1);
    repeat (3) cyc();
    idle8();

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst8 = ($urandom_range(0, 99) == 0);
      if8.fetch_start = ($urandom_range(0, 5) == 0);
      if8.mem_valid   = 1'($urandom_range(0, 1));
      if8.memdata     = 8'($urandom);
      if8.alusrca     = 1'($urandom);
      if8.alusrcb     = 2'($urandom);
      if8.alucontrol  = 3'($urandom);
      if8.pcsrc       = 2'($urandom);
      if8.pcwrite     = ($urandom_range(0, 3) == 0);
      if8.branch      = 1'($urandom);
      if8.iord        = 1'($urandom);
      if8.regwrite    = 1'($urandom);
      if8.regdst      = 1'($urandom);
      if8.memtoreg    = 1'($urandom);
      cyc();
    end
    rst8 = 0; idle8();

    // XLEN=16: stalled 2-beat fetch
    @(posedge clk); #1 rst16 = 0;
    if16.fetch_start = 1; @(posedge clk); #1 if16.fetch_start = 0;
    for (int i = 0; i < 5; i++) begin
      if16.mem_valid = mv_t[i][0];
      if16.memdata = (i == 1) ? 16'hBEEF : (i == 4) ? 16'h1234 : 16'hDEAD;
      #1;
      chk("f16_adr", if16.adr, adr_t[i]);
      chk("f16_busy", if16.fetch_busy, 1);
      chk("f16_pc", if16.pc, 0);
      @(posedge clk); #1;
    end
    if16.mem_valid = 1; if16.memdata = 16'h5555;
    chk("f16_instr", if16.instr, 32'h1234BEEF);
    chk("f16_idle", if16.fetch_busy, 0);
    chk("f16_done", if16.ir_done, 1);
    @(posedge clk); #1;
    chk("f16_instr_hold", if16.instr, 32'h1234BEEF);
    chk("f16_done_pulse", if16.ir_done, 0);
    chk("f16_pc_end", if16.pc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
